// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates at tail, captures CDB results, retires at head.
// Commit pulses appear one cycle after the retiring edge; a mispredicted branch flushes the whole ROB.
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_pred_taken,
    input  logic [31:0]              issue_alt_pc,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_value,
    output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    output logic                     rob_full,
    input  logic                     wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
    input  logic [31:0]              wb_value,
    input  logic                     wb_taken,
    output logic [4:0]               set_dep_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
    output logic [4:0]               set_reg_id,
    output logic [31:0]              set_val,
    output logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
    input  logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
    input  logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
    output logic                     rob_value1_ready,
    output logic                     rob_value2_ready,
    output logic [31:0]              rob_value1,
    output logic [31:0]              rob_value2,
    output logic                     store_commit,
    output logic [ROB_WIDTH_BIT-1:0] store_rob_id,
    output logic                     rob_clear,
    output logic [31:0]              clear_pc,
    output logic                     exit_commit
);
    localparam int RW    = ROB_WIDTH_BIT;
    localparam int DEPTH = 1 << RW;

    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;
    localparam logic [1:0] T_EXIT   = 2'd3;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pred_taken;
        logic        act_taken;
        logic [31:0] alt_pc;
    } entry_t;

    entry_t          rob_q [DEPTH];
    entry_t          rob_d [DEPTH];
    logic [RW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [RW:0]     count_q, count_d;

    logic [4:0]      set_reg_id_q, set_reg_id_d;
    logic [31:0]     set_val_q, set_val_d;
    logic [RW-1:0]   set_reg_on_rob_id_q, set_reg_on_rob_id_d;
    logic            store_commit_q, store_commit_d;
    logic [RW-1:0]   store_rob_id_q, store_rob_id_d;
    logic            rob_clear_q, rob_clear_d;
    logic [31:0]     clear_pc_q, clear_pc_d;
    logic            exit_commit_q, exit_commit_d;

    entry_t          head_e;
    logic            issue_ok, wb_ok, commit_ok;

    assign rob_full       = (count_q == (RW+1)'(DEPTH));
    assign issue_rob_id   = tail_q;
    assign set_dep_rob_id = tail_q;
    assign head_e         = rob_q[head_q];

    // While the flush pulse is out, nothing younger than the branch may be touched or retired.
    assign issue_ok  = rdy_in && !rob_clear_q && issue_valid && !rob_full;
    assign wb_ok     = rdy_in && !rob_clear_q && wb_valid && rob_q[wb_rob_id].busy;
    assign commit_ok = rdy_in && !rob_clear_q && head_e.busy && head_e.ready;

    assign set_dep_reg_id = issue_ok ? issue_rd : 5'd0;

    always_comb begin
        rob_value1_ready = rob_q[get_rob_id1].ready;
        rob_value1       = rob_q[get_rob_id1].value;
        rob_value2_ready = rob_q[get_rob_id2].ready;
        rob_value2       = rob_q[get_rob_id2].value;
        if (wb_valid && wb_rob_id == get_rob_id1) begin
            rob_value1_ready = 1'b1;
            rob_value1       = wb_value;
        end
        if (wb_valid && wb_rob_id == get_rob_id2) begin
            rob_value2_ready = 1'b1;
            rob_value2       = wb_value;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) rob_d[i] = rob_q[i];
        head_d              = head_q;
        tail_d              = tail_q;
        count_d             = count_q;
        set_reg_id_d        = 5'd0;
        set_val_d           = 32'd0;
        set_reg_on_rob_id_d = '0;
        store_commit_d      = 1'b0;
        store_rob_id_d      = '0;
        rob_clear_d         = 1'b0;
        clear_pc_d          = 32'd0;
        exit_commit_d       = 1'b0;

        if (rdy_in && rob_clear_q) begin
            for (int i = 0; i < DEPTH; i++) rob_d[i].busy = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy_in) begin
            if (wb_ok) begin
                rob_d[wb_rob_id].ready     = 1'b1;
                rob_d[wb_rob_id].value     = wb_value;
                rob_d[wb_rob_id].act_taken = wb_taken;
            end
            if (commit_ok) begin
                rob_d[head_q].busy = 1'b0;
                head_d             = head_q + 1'b1;
                case (head_e.typ)
                    T_REG: begin
                        set_reg_id_d        = head_e.rd;
                        set_val_d           = head_e.value;
                        set_reg_on_rob_id_d = head_q;
                    end
                    T_STORE: begin
                        store_commit_d = 1'b1;
                        store_rob_id_d = head_q;
                    end
                    T_BRANCH: begin
                        if (head_e.act_taken != head_e.pred_taken) begin
                            rob_clear_d = 1'b1;
                            clear_pc_d  = head_e.alt_pc;
                        end
                    end
                    T_EXIT:  exit_commit_d = 1'b1;
                    default: ;
                endcase
            end
            if (issue_ok) begin
                rob_d[tail_q].busy       = 1'b1;
                rob_d[tail_q].ready      = issue_ready;
                rob_d[tail_q].typ        = issue_type;
                rob_d[tail_q].rd         = issue_rd;
                rob_d[tail_q].value      = issue_value;
                rob_d[tail_q].pred_taken = issue_pred_taken;
                rob_d[tail_q].act_taken  = 1'b0;
                rob_d[tail_q].alt_pc     = issue_alt_pc;
                tail_d                   = tail_q + 1'b1;
            end
            count_d = count_q + (RW+1)'(issue_ok) - (RW+1)'(commit_ok);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
            head_q              <= '0;
            tail_q              <= '0;
            count_q             <= '0;
            set_reg_id_q        <= 5'd0;
            set_val_q           <= 32'd0;
            set_reg_on_rob_id_q <= '0;
            store_commit_q      <= 1'b0;
            store_rob_id_q      <= '0;
            rob_clear_q         <= 1'b0;
            clear_pc_q          <= 32'd0;
            exit_commit_q       <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) rob_q[i] <= rob_d[i];
            head_q              <= head_d;
            tail_q              <= tail_d;
            count_q             <= count_d;
            set_reg_id_q        <= set_reg_id_d;
            set_val_q           <= set_val_d;
            set_reg_on_rob_id_q <= set_reg_on_rob_id_d;
            store_commit_q      <= store_commit_d;
            store_rob_id_q      <= store_rob_id_d;
            rob_clear_q         <= rob_clear_d;
            clear_pc_q          <= clear_pc_d;
            exit_commit_q       <= exit_commit_d;
        end
    end

    assign set_reg_id        = set_reg_id_q;
    assign set_val           = set_val_q;
    assign set_reg_on_rob_id = set_reg_on_rob_id_q;
    assign store_commit      = store_commit_q;
    assign store_rob_id      = store_rob_id_q;
    assign rob_clear         = rob_clear_q;
    assign clear_pc          = clear_pc_q;
    assign exit_commit       = exit_commit_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table for basic retire paths, then hand sequences
// for full/wrap, forwarding order, mispredict flush, rdy_in pause and mid-flight reset.
module tb_reorder_buffer;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_valid, issue_pred_taken, issue_ready;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc, issue_value;
    logic [3:0]  issue_rob_id;
    logic        rob_full;
    logic        wb_valid, wb_taken;
    logic [3:0]  wb_rob_id;
    logic [31:0] wb_value;
    logic [4:0]  set_dep_reg_id, set_reg_id;
    logic [3:0]  set_dep_rob_id, set_reg_on_rob_id, get_rob_id1, get_rob_id2, store_rob_id;
    logic [31:0] set_val, rob_value1, rob_value2, clear_pc;
    logic        rob_value1_ready, rob_value2_ready, store_commit, rob_clear, exit_commit;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_WIDTH_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .issue_ready(issue_ready), .issue_value(issue_value),
        .issue_rob_id(issue_rob_id), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value), .wb_taken(wb_taken),
        .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
        .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
        .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .store_commit(store_commit), .store_rob_id(store_rob_id),
        .rob_clear(rob_clear), .clear_pc(clear_pc), .exit_commit(exit_commit)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [1:0]  it;
        logic [4:0]  ird;
        logic        ir;
        logic [31:0] ival;
        logic        wv;
        logic [3:0]  wid;
        logic [31:0] wval;
        logic        ck1;
        logic [3:0]  g1;
        logic [4:0]  e_dep;
        logic [3:0]  e_id;
        logic        e_r1;
        logic [31:0] e_v1;
        logic [4:0]  e_reg;
        logic [31:0] e_sval;
        logic [3:0]  e_rid;
        logic        e_st;
        logic [3:0]  e_stid;
        logic        e_ex;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pred_taken = 0;
        issue_alt_pc = 0; issue_ready = 0; issue_value = 0;
        wb_valid = 0; wb_rob_id = 0; wb_value = 0; wb_taken = 0;
        get_rob_id1 = 0; get_rob_id2 = 0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                         input logic [31:0] val, input logic pred, input logic [31:0] alt);
        issue_valid = 1; issue_type = t; issue_rd = rd; issue_ready = rdy;
        issue_value = val; issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    task automatic wb(input logic [3:0] id, input logic [31:0] val, input logic tk);
        wb_valid = 1; wb_rob_id = id; wb_value = val; wb_taken = tk;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 0; rdy_in = 1;
        step();
        rst_in = 1;
    endtask

    initial begin
        // iv it ird ir ival | wv wid wval | ck1 g1 | dep id r1 v1 | reg sval rid st stid ex
        vecs[0] = '{1, 0, 5, 1, 32'h1234, 0, 0, 0,     0, 0, 5, 0, 0, 0,     0, 0,       0, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 0,        0, 0, 0,     0, 0, 0, 1, 0, 0,     5, 32'h1234, 0, 0, 0, 0};
        vecs[2] = '{1, 1, 0, 0, 0,        0, 0, 0,     0, 0, 0, 1, 0, 0,     0, 0,       0, 0, 0, 0};
        vecs[3] = '{0, 0, 0, 0, 0,        1, 1, 32'hAA, 1, 1, 0, 2, 1, 32'hAA, 0, 0,     0, 0, 0, 0};
        vecs[4] = '{0, 0, 0, 0, 0,        0, 0, 0,     1, 1, 0, 2, 1, 32'hAA, 0, 0,      0, 1, 1, 0};
        vecs[5] = '{1, 3, 0, 1, 0,        0, 0, 0,     0, 0, 0, 2, 0, 0,     0, 0,       0, 0, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 0,        0, 0, 0,     0, 0, 0, 3, 0, 0,     0, 0,       0, 0, 0, 1};
        vecs[7] = '{0, 0, 0, 0, 0,        0, 0, 0,     0, 0, 0, 3, 0, 0,     0, 0,       0, 0, 0, 0};

        idle();
        rst_in = 0; rdy_in = 1;
        step();
        step();
        chk("reset rob_full", rob_full, 0);
        chk("reset issue_rob_id", issue_rob_id, 0);
        chk("reset set_reg_id", set_reg_id, 0);
        chk("reset store_commit", store_commit, 0);
        chk("reset rob_clear", rob_clear, 0);
        chk("reset exit_commit", exit_commit, 0);
        rst_in = 1;

        for (int i = 0; i < 8; i++) begin
            idle();
            issue_valid = vecs[i].iv; issue_type = vecs[i].it; issue_rd = vecs[i].ird;
            issue_ready = vecs[i].ir; issue_value = vecs[i].ival;
            wb_valid = vecs[i].wv; wb_rob_id = vecs[i].wid; wb_value = vecs[i].wval;
            get_rob_id1 = vecs[i].g1;
            #1;
            chk($sformatf("v%0d set_dep_reg_id", i), set_dep_reg_id, vecs[i].e_dep);
            chk($sformatf("v%0d issue_rob_id", i), issue_rob_id, vecs[i].e_id);
            chk($sformatf("v%0d rob_full", i), rob_full, 0);
            if (vecs[i].ck1) begin
                chk($sformatf("v%0d rob_value1_ready", i), rob_value1_ready, vecs[i].e_r1);
                chk($sformatf("v%0d rob_value1", i), rob_value1, vecs[i].e_v1);
            end
            step();
            chk($sformatf("v%0d set_reg_id", i), set_reg_id, vecs[i].e_reg);
            chk($sformatf("v%0d set_val", i), set_val, vecs[i].e_sval);
            chk($sformatf("v%0d set_reg_on_rob_id", i), set_reg_on_rob_id, vecs[i].e_rid);
            chk($sformatf("v%0d store_commit", i), store_commit, vecs[i].e_st);
            chk($sformatf("v%0d store_rob_id", i), store_rob_id, vecs[i].e_stid);
            chk($sformatf("v%0d exit_commit", i), exit_commit, vecs[i].e_ex);
        end

        // Fill all 16 entries, reject the 17th, then free one through writeback + commit.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle();
            issue(0, 5'(i + 1), 0, 0, 0, 0);
            #1;
            chk($sformatf("fill issue_rob_id %0d", i), issue_rob_id, i);
            chk($sformatf("fill set_dep_rob_id %0d", i), set_dep_rob_id, i);
            step();
        end
        idle();
        chk("full rob_full", rob_full, 1);
        chk("full tail wrapped", issue_rob_id, 0);
        issue(0, 5'd20, 1, 32'h5, 0, 0);
        #1;
        chk("full reject set_dep_reg_id", set_dep_reg_id, 0);
        step();
        chk("full tail unchanged", issue_rob_id, 0);
        chk("full still full", rob_full, 1);
        idle();
        wb(0, 32'h55, 0);
        get_rob_id1 = 1;
        #1;
        chk("full lookup not ready", rob_value1_ready, 0);
        step();
        idle();
        step();
        chk("full commit set_reg_id", set_reg_id, 1);
        chk("full commit set_val", set_val, 32'h55);
        chk("full freed rob_full", rob_full, 0);

        // CDB bypass on lookup, and younger ready entry waits for older head.
        do_reset();
        issue(0, 3, 0, 0, 0, 0); step();
        issue(0, 4, 0, 0, 0, 0); step();
        idle();
        wb(1, 32'd7, 0);
        get_rob_id1 = 1; get_rob_id2 = 0;
        #1;
        chk("fwd bypass ready1", rob_value1_ready, 1);
        chk("fwd bypass value1", rob_value1, 7);
        chk("fwd ready2 pending", rob_value2_ready, 0);
        step();
        idle();
        get_rob_id2 = 1;
        #1;
        chk("fwd stored ready2", rob_value2_ready, 1);
        chk("fwd stored value2", rob_value2, 7);
        step();
        chk("fwd no early commit a", set_reg_id, 0);
        step();
        chk("fwd no early commit b", set_reg_id, 0);
        wb(0, 32'd9, 0); step();
        idle(); step();
        chk("fwd commit0 rd", set_reg_id, 3);
        chk("fwd commit0 val", set_val, 9);
        chk("fwd commit0 id", set_reg_on_rob_id, 0);
        step();
        chk("fwd commit1 rd", set_reg_id, 4);
        chk("fwd commit1 val", set_val, 7);
        chk("fwd commit1 id", set_reg_on_rob_id, 1);

        // Mispredicted branch at head flushes younger entries.
        do_reset();
        issue(2, 0, 0, 0, 0, 32'h100); step();
        for (int i = 0; i < 3; i++) begin
            issue(0, 5'(10 + i), 0, 0, 0, 0); step();
        end
        idle();
        wb(0, 0, 1); step();
        idle(); step();
        chk("br rob_clear", rob_clear, 1);
        chk("br clear_pc", clear_pc, 32'h100);
        issue(0, 7, 1, 1, 0, 0);
        #1;
        chk("br flush blocks rename", set_dep_reg_id, 0);
        step();
        idle();
        chk("br rob_clear one cycle", rob_clear, 0);
        chk("br clear_pc dropped", clear_pc, 0);
        chk("br no commit after flush", set_reg_id, 0);
        chk("br tail reset", issue_rob_id, 0);
        chk("br not full", rob_full, 0);
        issue(0, 6, 0, 0, 0, 0);
        #1;
        chk("br post-flush rename", set_dep_reg_id, 6);
        chk("br post-flush id", set_dep_rob_id, 0);
        step();

        // rdy_in low holds everything; STORE pulse lasts exactly one cycle.
        do_reset();
        issue(1, 0, 0, 0, 0, 0); step();
        issue(0, 9, 1, 32'h77, 0, 0); step();
        idle();
        wb(0, 32'h1, 0); step();
        idle();
        rdy_in = 0;
        issue(0, 8, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("pause rename %0d", i), set_dep_reg_id, 0);
            step();
            chk($sformatf("pause store_commit %0d", i), store_commit, 0);
            chk($sformatf("pause set_reg_id %0d", i), set_reg_id, 0);
            chk($sformatf("pause tail %0d", i), issue_rob_id, 2);
        end
        idle();
        rdy_in = 1;
        step();
        chk("resume store_commit", store_commit, 1);
        chk("resume store_rob_id", store_rob_id, 0);
        step();
        chk("resume store pulse ends", store_commit, 0);
        chk("resume reg commit rd", set_reg_id, 9);
        chk("resume reg commit val", set_val, 32'h77);
        chk("resume reg commit id", set_reg_on_rob_id, 1);

        // Reset with 5 busy entries and a commit that would otherwise fire at that edge.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(0, 5'(i + 1), 0, 0, 0, 0); step();
        end
        idle();
        chk("pre-reset tail", issue_rob_id, 5);
        wb(0, 32'h99, 0); step();
        idle();
        rst_in = 0;
        step();
        rst_in = 1;
        chk("mid-reset rob_full", rob_full, 0);
        chk("mid-reset issue_rob_id", issue_rob_id, 0);
        chk("mid-reset set_reg_id", set_reg_id, 0);
        chk("mid-reset set_val", set_val, 0);
        chk("mid-reset store_commit", store_commit, 0);
        chk("mid-reset rob_clear", rob_clear, 0);
        chk("mid-reset exit_commit", exit_commit, 0);
        step();
        chk("mid-reset old head gone", set_reg_id, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer between issue/dispatch and RegisterFile.
- Allocates one entry per issued instruction and publishes its rd→ROB-id renaming to RegisterFile.
- Captures execution results from the common data bus (CDB) and serves operand-forwarding lookups.
- Commits at the head in program order; branch mispredicts at the head trigger a global flush.

Parameters:
- ROB_WIDTH_BIT, 4, log2 of entry count (DEPTH = 2**ROB_WIDTH_BIT = 16)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low (reset when rst_in==0 at posedge clk_in)
- rdy_in  in  1  ready; low pauses the block
- issue_valid  in  1  instruction offered for allocation
- issue_type  in  2  0=REG, 1=STORE, 2=BRANCH, 3=EXIT
- issue_rd  in  5  destination register (0 = none)
- issue_pred_taken  in  1  branch predicted taken
- issue_alt_pc  in  32  PC to redirect to if the prediction is wrong
- issue_ready  in  1  result already known at issue (e.g. LUI)
- issue_value  in  32  result, used when issue_ready=1
- issue_rob_id  out  ROB_WIDTH_BIT  id given to the offered instruction (= tail)
- rob_full  out  1  no free entry
- wb_valid  in  1  CDB result valid
- wb_rob_id  in  ROB_WIDTH_BIT  CDB target entry
- wb_value  in  32  CDB result
- wb_taken  in  1  actual branch outcome
- set_dep_reg_id  out  5  rename write to RegisterFile (0 = none)
- set_dep_rob_id  out  ROB_WIDTH_BIT  ROB id for the rename
- set_reg_id  out  5  commit register (0 = none)
- set_val  out  32  commit value
- set_reg_on_rob_id  out  ROB_WIDTH_BIT  id of the committing entry
- get_rob_id1 / get_rob_id2  in  ROB_WIDTH_BIT  operand lookup ids
- rob_value1_ready / rob_value2_ready  out  1  lookup result available
- rob_value1 / rob_value2  out  32  lookup value
- store_commit  out  1  head store retired this cycle
- store_rob_id  out  ROB_WIDTH_BIT  id of the retired store
- rob_clear  out  1  flush pulse
- clear_pc  out  32  redirect target
- exit_commit  out  1  EXIT instruction retired

Behaviour:
- State:
  - per entry: busy, ready, type, rd, value, pred_taken, alt_pc
  - head, tail (ROB_WIDTH_BIT, wrap modulo DEPTH)
  - count (ROB_WIDTH_BIT+1)
- Reset (rst_in==0 at edge):
  - all busy=0; head=tail=count=0
  - registered outputs 0: set_reg_id, set_val, set_reg_on_rob_id, store_commit, store_rob_id, rob_clear, clear_pc, exit_commit
- rdy_in==0: all state held; no issue, writeback or commit. The registered pulse outputs above are driven 0 at that edge.
- Combinational outputs:
  - rob_full = (count==DEPTH)
  - issue_rob_id = tail
  - set_dep_reg_id = issue_rd when (issue_valid && !rob_full && rdy_in && !rob_clear), else 0
  - set_dep_rob_id = tail
- Issue (accepted: issue_valid && !rob_full):
  - entry[tail] ← busy=1, ready=issue_ready, value=issue_value, remaining fields from issue_*
  - tail+1; count+1
- Writeback: wb_valid && busy[wb_rob_id] → ready=1, value=wb_value, actual-taken=wb_taken. Writeback to a non-busy entry is ignored.
- Lookup (combinational, per port n):
  - wb_valid && wb_rob_id==get_rob_idn → ready=1, value=wb_value (CDB bypass)
  - otherwise return the entry's ready/value
- Commit, at most one per cycle, when busy[head] && ready[head]:
  - REG: registered pulse set_reg_id=rd, set_val=value, set_reg_on_rob_id=head, valid for the cycle after the edge
  - STORE: store_commit=1, store_rob_id=head
  - EXIT: exit_commit=1
  - BRANCH, actual==pred: ordinary retire
  - BRANCH, actual!=pred: rob_clear=1 for one cycle, clear_pc=alt_pc
  - In all cases: busy[head]=0, head+1, count-1
- Flush, in the cycle rob_clear is high:
  - all busy=0; head=tail=count=0
  - issue and writeback ignored; set_dep_reg_id forced 0
- Same-cycle issue and commit: count unchanged.
  - Full: issue still rejected (rob_full uses registered count).
  - Empty (count==0): nothing commits; an entry issued with issue_ready=1 commits no earlier than the next cycle.
- Same-cycle writeback and commit of the same head entry: commit waits one cycle (ready is registered).
- Wrap-around: after DEPTH issues, tail returns to 0. Ids stay unique while busy.

Test Plan:
- Reset, then issue REG rd=5 with issue_ready=1, value 0x1234 → set_dep_reg_id=5, set_dep_rob_id=0 in the issue cycle; next cycle set_reg_id=5, set_val=0x1234, set_reg_on_rob_id=0.
- Issue 16 REG with no writeback → rob_full=1; a 17th issue_valid → set_dep_reg_id=0 and tail unchanged. Writeback id 0 → commit, then rob_full=0.
- Issue ids 0,1; wb_valid id 1 value 7 in the same cycle get_rob_id1=1 → rob_value1_ready=1, rob_value1=7. Id 1 must not commit before id 0.
- BRANCH pred_taken=0, alt_pc=0x100, followed by 3 REG; wb_taken=1 → one-cycle rob_clear with clear_pc=0x100; afterwards count=0 and the next issue gets issue_rob_id=0.
- STORE at head plus writeback → store_commit=1 with its store_rob_id for exactly one cycle. rdy_in=0 for 3 cycles mid-sequence → no commits, state preserved.
- Drive rst_in=0 while 5 entries are busy → next cycle rob_full=0, issue_rob_id=0, and all registered pulse outputs (set_reg_id, store_commit, rob_clear, exit_commit, etc.) are 0.
